// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded RV32I fields into instruction words behind an
// output register plus skid buffer, flagging illegal bundles and counting output words.
module rv_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_class,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             err_clear,
  output logic [CNT_W-1:0] instr_count
);
  logic [31:0] enc_instr, new_instr;
  logic enc_err, i_ok, b_ok, j_ok, u_ok, sh_ok, is_shift;
  logic accept, drain, load_o;
  logic o_valid_q, o_valid_d, o_err_q, o_err_d;
  logic s_valid_q, s_valid_d, s_err_q, s_err_d;
  logic err_sticky_q, err_sticky_d;
  logic [31:0] o_instr_q, o_instr_d, s_instr_q, s_instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Range checks reduce to sign-extension tests on the upper bits.
  always_comb begin
    i_ok = &in_imm[31:11] | ~|in_imm[31:11];
    b_ok = (&in_imm[31:12] | ~|in_imm[31:12]) & ~in_imm[0];
    j_ok = (&in_imm[31:20] | ~|in_imm[31:20]) & ~in_imm[0];
    u_ok = ~|in_imm[11:0];
    sh_ok = ~|in_imm[31:5];
    is_shift = in_funct3[1:0] == 2'b01;
    enc_instr = 32'h0;
    enc_err = 1'b0;
    case (in_class)
      3'd0: begin
        enc_instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        enc_err = !i_ok;
      end
      3'd1: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        enc_err = !i_ok;
      end
      3'd2: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd3: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
        enc_err = !b_ok;
      end
      3'd4: begin
        enc_instr = is_shift ? {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011}
                             : {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        enc_err = is_shift ? !sh_ok : !i_ok;
      end
      3'd5: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        enc_err = !j_ok;
      end
      3'd6: begin
        enc_instr = {in_imm[31:12], in_rd, 7'b0110111};
        enc_err = !u_ok;
      end
      default: begin
        enc_instr = {in_imm[31:12], in_rd, 7'b0010111};
        enc_err = !u_ok;
      end
    endcase
    new_instr = enc_err ? 32'h0000_0013 : enc_instr;
  end

  // O refills whenever it is empty or draining; S only catches a word while O stalls.
  always_comb begin
    accept = in_valid && !s_valid_q;
    drain = o_valid_q && out_ready;
    load_o = drain || !o_valid_q;
    o_valid_d = load_o ? (s_valid_q || accept) : o_valid_q;
    o_instr_d = (load_o && s_valid_q) ? s_instr_q : (load_o && accept) ? new_instr : o_instr_q;
    o_err_d = (load_o && s_valid_q) ? s_err_q : (load_o && accept) ? enc_err : o_err_q;
    s_valid_d = load_o ? 1'b0 : (s_valid_q || accept);
    s_instr_d = (!load_o && accept) ? new_instr : s_instr_q;
    s_err_d = (!load_o && accept) ? enc_err : s_err_q;
    cnt_d = cnt_q + CNT_W'(drain);
    err_sticky_d = (drain && o_err_q) || (err_sticky_q && !err_clear);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid_q <= 1'b0;
      o_instr_q <= 32'h0;
      o_err_q <= 1'b0;
      s_valid_q <= 1'b0;
      s_instr_q <= 32'h0;
      s_err_q <= 1'b0;
      cnt_q <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_instr_q <= o_instr_d;
      o_err_q <= o_err_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_err_q <= s_err_d;
      cnt_q <= cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign in_ready = !s_valid_q;
  assign out_valid = o_valid_q;
  assign out_instr = o_instr_q;
  assign out_err = o_err_q;
  assign err_sticky = err_sticky_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: directed vectors with hand-computed instruction words.
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic reset_n, in_valid, in_ready, out_valid, out_ready, out_err, err_sticky, err_clear;
  logic [2:0] in_class, in_funct3;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [6:0] in_funct7;
  logic [31:0] in_imm, out_instr;
  logic [15:0] instr_count;
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct packed {
    logic [2:0] c;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm, exp;
    logic err;
  } vec_t;

  rv_instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_sticky(err_sticky), .err_clear(err_clear),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
    put(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_chk++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    n_chk++; if (out_err !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b/%b exp 0/0", out_err, err_sticky); end
    n_chk++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", instr_count); end
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    put(3'd0, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 32'h0085_2283 || out_err !== 1'b0) begin n_fail++; $display("FAIL lw got v%b %h e%b exp v1 00852283 e0", out_valid, out_instr, out_err); end
    n_chk++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL lw_count_pre got %0d exp 0", instr_count); end
    tick();
    exp_cnt += 1;
    n_chk++; if (instr_count !== 16'(exp_cnt) || out_valid !== 1'b0) begin n_fail++; $display("FAIL lw_count got %0d v%b exp %0d v0", instr_count, out_valid, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    put(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 32'h0020_81B3) begin n_fail++; $display("FAIL b2b_add got v%b %h exp v1 002081b3", out_valid, out_instr); end
    put(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 32'hFE20_8EE3) begin n_fail++; $display("FAIL b2b_branch got v%b %h exp v1 fe208ee3", out_valid, out_instr); end
    tick();
    exp_cnt += 2;
    n_chk++; if (instr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_uj();
    put(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    n_chk++; if (out_instr !== 32'h1234_50B7 || out_err !== 1'b0) begin n_fail++; $display("FAIL lui got %h e%b exp 123450b7 e0", out_instr, out_err); end
    put(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_instr !== 32'h0010_00EF || out_err !== 1'b0) begin n_fail++; $display("FAIL jal got %h e%b exp 001000ef e0", out_instr, out_err); end
    tick();
    exp_cnt += 2;
  endtask

  task automatic test_errors();
    put(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin n_fail++; $display("FAIL err_branch got %h e%b exp 00000013 e1", out_instr, out_err); end
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_sticky_early got %b exp 0", err_sticky); end
    tick();
    n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_set got %b exp 1", err_sticky); end
    put(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1);
    tick();
    in_valid = 1'b0;
    err_clear = 1'b1;
    n_chk++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin n_fail++; $display("FAIL err_lui got %h e%b exp 00000013 e1", out_instr, out_err); end
    tick();
    n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_set_wins got %b exp 1", err_sticky); end
    tick();
    err_clear = 1'b0;
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err_sticky); end
    exp_cnt += 2;
  endtask

  task automatic test_encodings();
    vec_t tbl [13];
    tbl = '{
      '{3'd4, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'd3,         32'h0031_1093, 1'b0},
      '{3'd4, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd31,        32'h41F1_5093, 1'b0},
      '{3'd1, 5'd7, 5'd2, 5'd3, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0},
      '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,      32'h7FF0_0093, 1'b0},
      '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h0000_0013, 1'b1},
      '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0},
      '{3'd4, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'd32,        32'h0000_0013, 1'b1},
      '{3'd3, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'd4094,      32'h7E20_9FE3, 1'b0},
      '{3'd3, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'd4096,      32'h0000_0013, 1'b1},
      '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0},
      '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576,   32'h0000_0013, 1'b1},
      '{3'd7, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F117, 1'b0},
      '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd5,         32'h4020_81B3, 1'b0}
    };
    for (int i = 0; i < 13; i++) begin
      put(tbl[i].c, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
      tick();
      n_chk++; if (out_valid !== 1'b1 || out_instr !== tbl[i].exp || out_err !== tbl[i].err) begin n_fail++; $display("FAIL enc_%0d got v%b %h e%b exp v1 %h e%b", i, out_valid, out_instr, out_err, tbl[i].exp, tbl[i].err); end
    end
    in_valid = 1'b0;
    tick();
    exp_cnt += 13;
    n_chk++; if (instr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL enc_count got %0d exp %0d", instr_count, exp_cnt); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    n_chk++; if (in_ready !== 1'b0 || out_instr !== 32'h0010_0093) begin n_fail++; $display("FAIL bp_full got r%b %h exp r0 00100093", in_ready, out_instr); end
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h0010_0093) begin n_fail++; $display("FAIL bp_hold got r%b v%b %h exp r0 v1 00100093", in_ready, out_valid, out_instr); end
    out_ready = 1'b1;
    tick();
    n_chk++; if (in_ready !== 1'b1 || out_instr !== 32'h0020_0093) begin n_fail++; $display("FAIL bp_second got r%b %h exp r1 00200093", in_ready, out_instr); end
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 32'h0030_0093) begin n_fail++; $display("FAIL bp_third got v%b %h exp v1 00300093", out_valid, out_instr); end
    tick();
    exp_cnt += 3;
    n_chk++; if (out_valid !== 1'b0 || instr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_done got v%b cnt %0d exp v0 cnt %0d", out_valid, instr_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    put(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    in_valid = 1'b0;
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL rm_pre got r%b v%b s%b exp r0 v1 s1", in_ready, out_valid, err_sticky); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_flags got v%b r%b exp v0 r1", out_valid, in_ready); end
    n_chk++; if (instr_count !== 16'd0 || err_sticky !== 1'b0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL rm_state got cnt %0d s%b %h exp 0 0 0", instr_count, err_sticky, out_instr); end
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0 || instr_count !== 16'd0) begin n_fail++; $display("FAIL rm_after got v%b cnt %0d exp v0 0", out_valid, instr_count); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_uj();
    test_errors();
    test_encodings();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
